pc_fetch_unit: RTL

Program counter, 8-level hardware return stack and instruction register for the PIC16F core. The block sits directly upstream of the instruction decoder. It drives the 13-bit program-memory address and captures the returned 14-bit word into `instr_current`. It applies the decoder's per-cycle control strobes to advance, skip, branch, call or return.

---
 rtl/pc_fetch_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter, hardware return stack and instruction register for the
// PIC16F core. It sits directly upstream of the instruction decoder. It
// drives the program-memory address, captures the returned word into the
// instruction register, and applies the decoder's per-cycle control strobes.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   prog_addr      program memory address (combinationally equal to pc)
//   prog_data      program memory word at prog_addr (asynchronous read)
//   instr_current  instruction register, feeds the decoder
//   pc             current PC, the address of the next word to load
//   instr_rd_en    load prog_data into IR
//   instr_flush    load NOP (14'h0000) into IR; wins over instr_rd_en
//   pc_incr_en     PC <= PC + 1
//   pc_j_en        goto:  PC <= {pclath[4:3], IR[10:0]}
//   pc_call_en     call:  push PC, then jump as for goto
//   pc_ret_en      return: PC <= popped value
//   pcl_wr_en      PCL write: PC <= {pclath[4:0], pcl_wr_data}
//   pcl_wr_data    new PCL value
//   pclath         PCLATH register contents
//   stack_ovf      sticky, set by a push while the stack is full
//   stack_unf      sticky, set by a pop while the stack is empty
//   dbg_depth_o    debug: number of valid stack entries
//   dbg_sp_o       debug: stack pointer (next free slot)
//
// Control interface: the strobes carry no valid/ready handshake. Each strobe
// is a level sampled on every rising edge. A strobe held high re-applies its
// action every cycle, and the block never back-pressures the decoder.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int PC_WIDTH    = 13,
  parameter int STACK_DEPTH = 8   // must be a power of 2
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [PC_WIDTH-1:0]            prog_addr,
  input  logic [13:0]                    prog_data,
  output logic [13:0]                    instr_current,
  output logic [PC_WIDTH-1:0]            pc,
  input  logic                           instr_rd_en,
  input  logic                           instr_flush,
  input  logic                           pc_incr_en,
  input  logic                           pc_j_en,
  input  logic                           pc_call_en,
  input  logic                           pc_ret_en,
  input  logic                           pcl_wr_en,
  input  logic [7:0]                     pcl_wr_data,
  input  logic [4:0]                     pclath,
  output logic                           stack_ovf,
  output logic                           stack_unf,
  output logic [$clog2(STACK_DEPTH):0]   dbg_depth_o,
  output logic [$clog2(STACK_DEPTH)-1:0] dbg_sp_o
);

  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam int DW   = SP_W + 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PC_WIDTH-1:0] pc_q,    pc_d;
  logic [13:0]         ir_q,    ir_d;
  logic [SP_W-1:0]     sp_q,    sp_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic                ovf_q,   ovf_d;
  logic                unf_q,   unf_d;

  // The return stack has no reset. Its contents are only ever read after
  // being written, except on an underflow pop, where the result is whatever
  // the wrapped slot happens to hold (as on the real part).
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  // -------------------------------------------------------------------------
  // Derived values
  // -------------------------------------------------------------------------
  logic [PC_WIDTH-1:0] jump_tgt;
  logic [PC_WIDTH-1:0] pcl_tgt;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [SP_W-1:0]     sp_inc;
  logic [SP_W-1:0]     sp_dec;
  logic [PC_WIDTH-1:0] pop_val;
  logic                do_push;

  // The jump target uses the IR as it stands this cycle, before any IR load
  // or flush requested by the same strobe set.
  assign jump_tgt = PC_WIDTH'({pclath[4:3], ir_q[10:0]});
  assign pcl_tgt  = PC_WIDTH'({pclath, pcl_wr_data});
  assign pc_plus1 = pc_q + PC_WIDTH'(1);  // wraps modulo 2^PC_WIDTH

  // The pointer width matches the depth exactly, so +1/-1 wrap naturally.
  assign sp_inc  = sp_q + SP_W'(1);
  assign sp_dec  = sp_q - SP_W'(1);
  assign pop_val = stack_q[sp_dec];

  // -------------------------------------------------------------------------
  // Instruction register next state: flush beats read, otherwise hold.
  // -------------------------------------------------------------------------
  always_comb begin
    ir_d = ir_q;
    if (instr_flush) begin
      ir_d = 14'h0000;
    end else if (instr_rd_en) begin
      ir_d = prog_data;
    end
  end

  // -------------------------------------------------------------------------
  // PC / stack next state. Exactly one PC action is taken per cycle, picked
  // in priority order: return, call, goto, PCL write, increment, hold.
  // A return with a simultaneous call therefore performs only the pop.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    do_push = 1'b0;

    if (pc_ret_en) begin
      pc_d = pop_val;
      sp_d = sp_dec;
      // An empty-stack pop still moves the pointer and loads the wrapped
      // slot. Only the depth counter saturates at zero.
      if (depth_q == '0) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - DW'(1);
      end
    end else if (pc_call_en) begin
      do_push = 1'b1;
      pc_d    = jump_tgt;
      sp_d    = sp_inc;
      // A full-stack push overwrites the oldest entry (circular buffer), and
      // the depth stays at full.
      if (depth_q == DEPTH_FULL) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + DW'(1);
      end
    end else if (pc_j_en) begin
      pc_d = jump_tgt;
    end else if (pcl_wr_en) begin
      pc_d = pcl_tgt;
    end else if (pc_incr_en) begin
      pc_d = pc_plus1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= 14'h0000;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // The return address pushed is the current PC, which already points at
  // the word after the call because the call word was fetched with an
  // increment.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      stack_q[sp_q] <= pc_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pc            = pc_q;
  assign prog_addr     = pc_q;
  assign instr_current = ir_q;
  assign stack_ovf     = ovf_q;
  assign stack_unf     = unf_q;
  assign dbg_depth_o   = depth_q;
  assign dbg_sp_o      = sp_q;

endmodule
